// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback, M-unit and scoreboard signals between the pipeline and the write-side arbiter
interface wb_arbiter_if;
    logic        PIPE_WEN;
    logic [4:0]  PIPE_RD;
    logic [31:0] PIPE_DATA;
    logic        M_ISSUE;
    logic [4:0]  M_ISSUE_RD;
    logic        M_VALID;
    logic [4:0]  M_RD;
    logic [31:0] M_DATA;
    logic        M_READY;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic        HAZARD;
    logic        DRAIN_REQ;
    logic        WRITE_EN;
    logic [4:0]  WRITE_ADDR;
    logic [31:0] WRITE_DATA;
    logic [31:0] BUSY_MASK;

    modport master (
        output PIPE_WEN, PIPE_RD, PIPE_DATA, M_ISSUE, M_ISSUE_RD, M_VALID, M_RD, M_DATA, RS1, RS2,
        input  M_READY, HAZARD, DRAIN_REQ, WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY_MASK
    );

    modport slave (
        input  PIPE_WEN, PIPE_RD, PIPE_DATA, M_ISSUE, M_ISSUE_RD, M_VALID, M_RD, M_DATA, RS1, RS2,
        output M_READY, HAZARD, DRAIN_REQ, WRITE_EN, WRITE_ADDR, WRITE_DATA, BUSY_MASK
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline writebacks and buffered M-unit results onto one register-file write port
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input logic        CLK,
    input logic        RESET,
    wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    mem_rd_q [DEPTH];
    logic [4:0]    mem_rd_d [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_data_d [DEPTH];
    logic [31:0]   busy_q, busy_d;
    logic          write_en_q, write_en_d;
    logic [4:0]    write_addr_q, write_addr_d;
    logic [31:0]   write_data_q, write_data_d;
    logic          empty, full, push, pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_data, set_mask, clr_mask;

    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push      = bus.M_VALID && !full;
    assign pop       = !bus.PIPE_WEN && !empty;
    assign head_rd   = mem_rd_q[rd_ptr_q[AW-1:0]];
    assign head_data = mem_data_q[rd_ptr_q[AW-1:0]];

    assign bus.M_READY    = !full;
    assign bus.DRAIN_REQ  = full;
    assign bus.HAZARD     = busy_q[bus.RS1] | busy_q[bus.RS2];
    assign bus.BUSY_MASK  = busy_q;
    assign bus.WRITE_EN   = write_en_q;
    assign bus.WRITE_ADDR = write_addr_q;
    assign bus.WRITE_DATA = write_data_q;

    // FIFO next state: push at the tail, pop the head only when it wins arbitration
    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        if (push) begin
            mem_rd_d[wr_ptr_q[AW-1:0]]   = bus.M_RD;
            mem_data_d[wr_ptr_q[AW-1:0]] = bus.M_DATA;
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    // Write port: pipeline first, then FIFO head; x0 destinations are emitted with the enable suppressed
    always_comb begin
        write_en_d   = bus.PIPE_WEN ? (bus.PIPE_RD != 5'd0) : pop ? (head_rd != 5'd0) : 1'b0;
        write_addr_d = bus.PIPE_WEN ? bus.PIPE_RD : pop ? head_rd : write_addr_q;
        write_data_d = bus.PIPE_WEN ? bus.PIPE_DATA : pop ? head_data : write_data_q;
    end

    // Scoreboard: clear on M emit, set on M issue (set applied last so it wins), x0 never busy
    always_comb begin
        clr_mask = pop ? (32'd1 << head_rd) : 32'd0;
        set_mask = (bus.M_ISSUE && bus.M_ISSUE_RD != 5'd0) ? (32'd1 << bus.M_ISSUE_RD) : 32'd0;
        busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    // State registers with asynchronous reset dropping buffered results and busy bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_rd_q     <= '{default: '0};
            mem_data_q   <= '{default: '0};
            busy_q       <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_rd_q     <= mem_rd_d;
            mem_data_q   <= mem_data_d;
            busy_q       <= busy_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenario tests for the writeback arbiter with DEPTH=2
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    logic [4:0] pend[$];

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(2)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Illegal-input monitors, using a shadow queue of buffered destinations to know which rd is cleared this edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
        end else begin : mon
            bit ex;
            ex = !bus.PIPE_WEN && pend.size() != 0 && pend[0] == bus.M_ISSUE_RD;
            assert (!(bus.M_ISSUE && bus.M_ISSUE_RD != 5'd0 && bus.BUSY_MASK[bus.M_ISSUE_RD] && !ex))
                else $error("illegal M_ISSUE to busy rd %0d", bus.M_ISSUE_RD);
            assert (!(bus.PIPE_WEN && bus.PIPE_RD != 5'd0 && bus.BUSY_MASK[bus.PIPE_RD]))
                else $error("illegal PIPE_WEN to busy rd %0d", bus.PIPE_RD);
            if (!bus.PIPE_WEN && pend.size() != 0) void'(pend.pop_front());
            if (bus.M_VALID && bus.M_READY) pend.push_back(bus.M_RD);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        bus.PIPE_WEN = 0; bus.PIPE_RD = 0; bus.PIPE_DATA = 0;
        bus.M_ISSUE = 0; bus.M_ISSUE_RD = 0;
        bus.M_VALID = 0; bus.M_RD = 0; bus.M_DATA = 0;
    endtask

    task automatic test_reset;
        clr_in();
        bus.RS1 = 0; bus.RS2 = 0;
        tick();
        checks++; if (bus.WRITE_EN !== 1'b0) begin errs++; $display("FAIL rst_wen: got %b want 0", bus.WRITE_EN); end
        checks++; if (bus.M_READY !== 1'b1) begin errs++; $display("FAIL rst_mready: got %b want 1", bus.M_READY); end
        checks++; if (bus.BUSY_MASK !== 32'd0) begin errs++; $display("FAIL rst_busy: got %h want 0", bus.BUSY_MASK); end
        rst = 0;
        bus.PIPE_WEN = 1; bus.PIPE_RD = 4; bus.PIPE_DATA = 32'h1234;
        bus.M_ISSUE = 1; bus.M_ISSUE_RD = 6; bus.RS1 = 6;
        tick();
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd4, 32'h1234})
            begin errs++; $display("FAIL pre_wr: got %b/%0d/%h want 1/4/1234", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if (bus.HAZARD !== 1'b1) begin errs++; $display("FAIL pre_hazard: got %b want 1", bus.HAZARD); end
        bus.M_ISSUE = 0; bus.PIPE_DATA = 32'h5678;
        bus.M_VALID = 1; bus.M_RD = 6; bus.M_DATA = 32'hAA;
        tick();
        clr_in();
        #2 rst = 1;
        #1;
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== 38'd0)
            begin errs++; $display("FAIL async_wr: got %b/%0d/%h want 0/0/0", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if (bus.BUSY_MASK !== 32'd0) begin errs++; $display("FAIL async_busy: got %h want 0", bus.BUSY_MASK); end
        checks++; if ({bus.M_READY, bus.DRAIN_REQ, bus.HAZARD} !== 3'b100)
            begin errs++; $display("FAIL async_flags: got %b want 100", {bus.M_READY, bus.DRAIN_REQ, bus.HAZARD}); end
        #1 rst = 0;
        bus.RS1 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.WRITE_EN !== 1'b0) begin errs++; $display("FAIL idle_wen%0d: got %b want 0", i, bus.WRITE_EN); end
        end
    endtask

    task automatic test_scoreboard;
        bus.M_ISSUE = 1; bus.M_ISSUE_RD = 5; bus.RS1 = 5;
        tick();
        bus.M_ISSUE = 0;
        checks++; if (bus.BUSY_MASK !== 32'h20) begin errs++; $display("FAIL sb_busy: got %h want 20", bus.BUSY_MASK); end
        checks++; if (bus.HAZARD !== 1'b1) begin errs++; $display("FAIL sb_hazard: got %b want 1", bus.HAZARD); end
        bus.M_VALID = 1; bus.M_RD = 5; bus.M_DATA = 32'hDEADBEEF;
        tick();
        bus.M_VALID = 0;
        checks++; if (bus.WRITE_EN !== 1'b0) begin errs++; $display("FAIL sb_nobypass: got %b want 0", bus.WRITE_EN); end
        checks++; if (bus.HAZARD !== 1'b1) begin errs++; $display("FAIL sb_hazard_hold: got %b want 1", bus.HAZARD); end
        tick();
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin errs++; $display("FAIL sb_wr: got %b/%0d/%h want 1/5/deadbeef", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if (bus.HAZARD !== 1'b0) begin errs++; $display("FAIL sb_hazard_clr: got %b want 0", bus.HAZARD); end
        checks++; if (bus.BUSY_MASK !== 32'd0) begin errs++; $display("FAIL sb_busy_clr: got %h want 0", bus.BUSY_MASK); end
        bus.RS1 = 0;
    endtask

    task automatic test_priority;
        bus.M_ISSUE = 1; bus.M_ISSUE_RD = 3;
        tick();
        bus.M_ISSUE = 0;
        bus.M_VALID = 1; bus.M_RD = 3; bus.M_DATA = 32'h33;
        bus.PIPE_WEN = 1; bus.PIPE_RD = 7; bus.PIPE_DATA = 32'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.M_VALID = 0;
            checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd7, 32'h11})
                begin errs++; $display("FAIL prio_x7_%0d: got %b/%0d/%h want 1/7/11", i, bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        end
        bus.PIPE_WEN = 0;
        tick();
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd3, 32'h33})
            begin errs++; $display("FAIL prio_x3: got %b/%0d/%h want 1/3/33", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        tick();
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b0, 5'd3, 32'h33})
            begin errs++; $display("FAIL prio_hold: got %b/%0d/%h want 0/3/33", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if (bus.BUSY_MASK !== 32'd0) begin errs++; $display("FAIL prio_busy: got %h want 0", bus.BUSY_MASK); end
    endtask

    task automatic test_full;
        for (int r = 10; r < 13; r++) begin
            bus.M_ISSUE = 1; bus.M_ISSUE_RD = 5'(r);
            tick();
        end
        bus.M_ISSUE = 0;
        checks++; if (bus.BUSY_MASK !== 32'h1C00) begin errs++; $display("FAIL full_busy0: got %h want 1c00", bus.BUSY_MASK); end
        bus.PIPE_WEN = 1; bus.PIPE_RD = 20; bus.PIPE_DATA = 32'h1;
        bus.M_VALID = 1; bus.M_RD = 10; bus.M_DATA = 32'hA;
        tick();
        checks++; if ({bus.M_READY, bus.DRAIN_REQ} !== 2'b10) begin errs++; $display("FAIL full_one: got %b want 10", {bus.M_READY, bus.DRAIN_REQ}); end
        bus.M_RD = 11; bus.M_DATA = 32'hB;
        tick();
        checks++; if ({bus.M_READY, bus.DRAIN_REQ} !== 2'b01) begin errs++; $display("FAIL full_two: got %b want 01", {bus.M_READY, bus.DRAIN_REQ}); end
        bus.M_RD = 12; bus.M_DATA = 32'hC;
        tick();
        checks++; if ({bus.M_READY, bus.DRAIN_REQ} !== 2'b01) begin errs++; $display("FAIL full_held: got %b want 01", {bus.M_READY, bus.DRAIN_REQ}); end
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR} !== {1'b1, 5'd20}) begin errs++; $display("FAIL full_pipe: got %b/%0d want 1/20", bus.WRITE_EN, bus.WRITE_ADDR); end
        bus.PIPE_WEN = 0;
        tick();
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd10, 32'hA})
            begin errs++; $display("FAIL full_drain: got %b/%0d/%h want 1/10/a", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if ({bus.M_READY, bus.DRAIN_REQ} !== 2'b10) begin errs++; $display("FAIL full_ready: got %b want 10", {bus.M_READY, bus.DRAIN_REQ}); end
        checks++; if (bus.BUSY_MASK !== 32'h1800) begin errs++; $display("FAIL full_busy1: got %h want 1800", bus.BUSY_MASK); end
        tick();
        bus.M_VALID = 0;
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd11, 32'hB})
            begin errs++; $display("FAIL full_pushpop: got %b/%0d/%h want 1/11/b", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if ({bus.M_READY, bus.DRAIN_REQ} !== 2'b10) begin errs++; $display("FAIL full_count: got %b want 10", {bus.M_READY, bus.DRAIN_REQ}); end
        tick();
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd12, 32'hC})
            begin errs++; $display("FAIL full_last: got %b/%0d/%h want 1/12/c", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        tick();
        checks++; if (bus.WRITE_EN !== 1'b0) begin errs++; $display("FAIL full_empty: got %b want 0", bus.WRITE_EN); end
        checks++; if (bus.BUSY_MASK !== 32'd0) begin errs++; $display("FAIL full_busy2: got %h want 0", bus.BUSY_MASK); end
    endtask

    task automatic test_x0_setclr;
        bus.M_ISSUE = 1; bus.M_ISSUE_RD = 0;
        tick();
        bus.M_ISSUE = 0;
        checks++; if (bus.BUSY_MASK !== 32'd0) begin errs++; $display("FAIL x0_issue: got %h want 0", bus.BUSY_MASK); end
        bus.M_VALID = 1; bus.M_RD = 0; bus.M_DATA = 32'h99;
        tick();
        bus.M_VALID = 0;
        bus.M_ISSUE = 1; bus.M_ISSUE_RD = 9;
        tick();
        bus.M_ISSUE = 0;
        checks++; if (bus.WRITE_EN !== 1'b0) begin errs++; $display("FAIL x0_pop_wen: got %b want 0", bus.WRITE_EN); end
        checks++; if (bus.BUSY_MASK !== 32'h200) begin errs++; $display("FAIL x0_busy: got %h want 200", bus.BUSY_MASK); end
        bus.M_VALID = 1; bus.M_RD = 9; bus.M_DATA = 32'h9;
        tick();
        bus.M_VALID = 0;
        bus.M_ISSUE = 1; bus.M_ISSUE_RD = 9;
        tick();
        bus.M_ISSUE = 0;
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd9, 32'h9})
            begin errs++; $display("FAIL sc_wr: got %b/%0d/%h want 1/9/9", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if (bus.BUSY_MASK !== 32'h200) begin errs++; $display("FAIL sc_setwins: got %h want 200", bus.BUSY_MASK); end
        bus.M_VALID = 1; bus.M_RD = 9; bus.M_DATA = 32'h19;
        tick();
        bus.M_VALID = 0;
        tick();
        checks++; if ({bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA} !== {1'b1, 5'd9, 32'h19})
            begin errs++; $display("FAIL sc_wr2: got %b/%0d/%h want 1/9/19", bus.WRITE_EN, bus.WRITE_ADDR, bus.WRITE_DATA); end
        checks++; if (bus.BUSY_MASK !== 32'd0) begin errs++; $display("FAIL sc_busy_end: got %h want 0", bus.BUSY_MASK); end
    endtask

    initial begin
        test_reset();
        test_scoreboard();
        test_priority();
        test_full();
        test_x0_setclr();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
